instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have ports req_valid (in, 1) and req_ready (out, 1): request handshake; transfer occurs when both are high.
REQ-004 SHALL have port fmt, input, 3: 0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=LUI, 6=JAL; 7 is illegal.
REQ-005 SHALL have port alu_op, input, 4: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 sra, 7 or, 8 and, 9 sub, 10 lui.
REQ-006 SHALL have ports mask (in, 3) and br_type (in, 3): funct3 for LOAD/STORE and BRANCH.
REQ-007 SHALL have ports rd, rs1, rs2 (in, 5 each) and imm (in, 32, byte-offset/value, sign-extended).
REQ-008 SHALL have ports out_valid (out, 1) and out_ready (in, 1): output handshake.
REQ-009 SHALL have ports instr (out, 32), addr (out, 32), illegal (out, 1) and err_cnt (out, 8).

Function
REQ-010 SHALL be a 2-stage pipeline: S1 registers request and selects format/funct fields plus legality; S2 assembles immediates and the word.
REQ-011 SHALL assert out_valid 2 cycles after an accepted request when out_ready stays high; throughput is 1 per cycle.
REQ-012 SHALL drive req_ready = !S1_valid | S1 advances; a stage advances when its successor is empty or draining.
REQ-013 SHALL hold instr, addr and illegal stable while out_valid=1 and out_ready=0; no request is lost or reordered.
REQ-014 R: opcode 0110011; funct3 per alu_op (add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111); funct7 0100000 for sub/sra, else 0; alu_op 10 illegal.
REQ-015 I-ALU: opcode 0010011; same funct3 map; sll/srl/sra use imm[4:0] with funct7 0000000 (sll/srl) or 0100000 (sra); shamt >31 is illegal; sub and lui are illegal.
REQ-016 LOAD: opcode 0000011, funct3=mask; masks 3, 6, 7 are illegal. STORE: opcode 0100011, funct3=mask; masks other than 0-2 are illegal.
REQ-017 I/LOAD/STORE imm SHALL fit signed 12 bits, else illegal; STORE splits imm[11:5]->[31:25] and imm[4:0]->[11:7].
REQ-018 BRANCH: opcode 1100011, funct3=br_type (2, 3 illegal); imm signed 13 bits with imm[0]=0, placed as [12|10:5] and [4:1|11].
REQ-019 LUI: opcode 0110111, instr[31:12]=imm[31:12]; imm[11:0]!=0 is illegal.
REQ-020 JAL: opcode 1101111; imm signed 21 bits with imm[0]=0, placed as [20|10:1|11|19:12].
REQ-021 Illegal request: instr=32'h00000013 (nop) with illegal=1; it is still emitted and consumes an address.
REQ-022 addr SHALL start at 0 and increment by 4 on each output handshake, wrapping 0xFFFFFFFC->0.
REQ-023 err_cnt SHALL increment on each output handshake with illegal=1 and saturate at 255.
REQ-024 Fields unused by a format (e.g. rs2 for I) SHALL be ignored.

Reset
REQ-025 While reset=1, the block SHALL clear all stage-valid flags and drive out_valid=0, req_ready=0, instr=0, addr=0, illegal=0, err_cnt=0.
REQ-026 Reset mid-operation SHALL discard in-flight requests; req_ready=1 on the first cycle after reset deasserts.

Structure
REQ-027 fmt encoding, alu_op codes, opcode constants and the nop constant SHALL live in shared package riscv_pkg, which the decoder also uses.
REQ-028 Immediate packing SHALL be one sub-module, imm_packer: combinational, fmt+imm in, 32-bit immediate bit-field out.

Verification
REQ-029 R, alu_op 0, rd=3, rs1=1, rs2=2 -> instr 0x002081B3 at cycle+2, addr 0; same with alu_op 9 -> 0x402081B3, addr 4.
REQ-030 I-ALU addi, rd=1, rs1=0, imm=0xFFFFFFFF -> 0xFFF00093; imm=2048 -> 0x00000013, illegal=1, err_cnt=1.
REQ-031 BRANCH br_type 0, rs1=1, rs2=2, imm=8 -> 0x00208463; JAL rd=1, imm=2048 -> 0x001000EF.
REQ-032 LOAD mask 3 -> nop, illegal=1; 256 consecutive illegal requests -> err_cnt holds 255.
REQ-033 Three back-to-back requests with out_ready=0 for 3 cycles -> req_ready falls once both stages are full, outputs appear in order at addr 0, 4, 8, and no instr changes while stalled.
REQ-034 Reset asserted with 2 requests in flight -> next cycle out_valid=0, addr=0, err_cnt=0; the next request emits at addr 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared format codes, ALU op codes, opcodes and decoded-request record
package riscv_pkg;
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_LOAD, FMT_STORE, FMT_BRANCH, FMT_LUI, FMT_JAL, FMT_ILL
  } fmt_e;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_SUB  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  // Register-side fields of the word plus the immediate still to be packed
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;
  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    return op == ALU_SUB ? 3'd0 : op == ALU_SRA ? 3'd5 : op == ALU_OR ? 3'd6 :
           op == ALU_AND ? 3'd7 : op[2:0];
  endfunction
endpackage

// File: rtl/imm_packer.sv
// imm_packer: scatters an immediate into its instruction bit positions for a format
module imm_packer
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits
);
  // Immediate bits land in place; every other bit is zero so the caller can OR in fields
  always_comb begin
    imm_bits = '0;
    case (fmt)
      FMT_I, FMT_LOAD: imm_bits = {imm[11:0], 20'd0};
      FMT_STORE:       imm_bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
      FMT_BRANCH:      imm_bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
      FMT_LUI:         imm_bits = {imm[31:12], 12'd0};
      FMT_JAL:         imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
      default:         imm_bits = '0;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage pipelined RV32 instruction word encoder with address and error count
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  fmt,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  mask,
  input  logic [2:0]  br_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] addr,
  output logic        illegal,
  output logic [7:0]  err_cnt
);
  dec_t        dec, s1_q;
  logic        s1_valid_q, s2_valid_q, illegal_q;
  logic        is_shift, fit12, fit13, fit21, s1_adv, s1_load, s2_load, out_hs;
  logic [31:0] instr_q, instr_d, addr_q, imm_bits;
  logic [7:0]  err_q;

  assign is_shift = alu_op == ALU_SLL || alu_op == ALU_SRL || alu_op == ALU_SRA;
  assign fit12    = &imm[31:11] || ~|imm[31:11];
  assign fit13    = &imm[31:12] || ~|imm[31:12];
  assign fit21    = &imm[31:20] || ~|imm[31:20];
  assign s1_adv   = !s2_valid_q || out_ready;
  assign req_ready = !reset && (!s1_valid_q || s1_adv);
  assign s1_load  = req_valid && req_ready;
  assign s2_load  = s1_valid_q && s1_adv;
  assign out_hs   = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q && !reset;
  assign instr     = reset ? '0 : instr_q;
  assign addr      = reset ? '0 : addr_q;
  assign illegal   = !reset && illegal_q;
  assign err_cnt   = reset ? '0 : err_q;

  // Stage-1 decode: pick opcode/funct fields, zero unused register fields, judge legality
  always_comb begin
    dec = '0;
    dec.fmt = fmt;
    dec.imm = imm;
    dec.illegal = 1'b1;
    case (fmt)
      FMT_R: begin
        dec.opcode  = OP_R;
        dec.rd      = rd;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.funct3  = alu_funct3(alu_op);
        dec.funct7  = (alu_op == ALU_SUB || alu_op == ALU_SRA) ? 7'h20 : 7'h00;
        dec.illegal = alu_op > ALU_SUB;
      end
      FMT_I: begin
        dec.opcode  = OP_IMM;
        dec.rd      = rd;
        dec.rs1     = rs1;
        dec.funct3  = alu_funct3(alu_op);
        dec.imm     = is_shift ? {20'd0, (alu_op == ALU_SRA) ? 7'h20 : 7'h00, imm[4:0]} : imm;
        dec.illegal = alu_op >= ALU_SUB || (is_shift ? |imm[31:5] : !fit12);
      end
      FMT_LOAD: begin
        dec.opcode  = OP_LOAD;
        dec.rd      = rd;
        dec.rs1     = rs1;
        dec.funct3  = mask;
        dec.illegal = mask inside {3'd3, 3'd6, 3'd7} || !fit12;
      end
      FMT_STORE: begin
        dec.opcode  = OP_STORE;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.funct3  = mask;
        dec.illegal = mask > 3'd2 || !fit12;
      end
      FMT_BRANCH: begin
        dec.opcode  = OP_BRANCH;
        dec.rs1     = rs1;
        dec.rs2     = rs2;
        dec.funct3  = br_type;
        dec.illegal = br_type inside {3'd2, 3'd3} || !fit13 || imm[0];
      end
      FMT_LUI: begin
        dec.opcode  = OP_LUI;
        dec.rd      = rd;
        dec.illegal = |imm[11:0];
      end
      FMT_JAL: begin
        dec.opcode  = OP_JAL;
        dec.rd      = rd;
        dec.illegal = !fit21 || imm[0];
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  imm_packer u_pack (
    .fmt      (s1_q.fmt),
    .imm      (s1_q.imm),
    .imm_bits (imm_bits)
  );

  assign instr_d = s1_q.illegal ? NOP :
                   imm_bits | {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};

  // Pipeline valids, stage payloads, output address and saturating error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      instr_q    <= '0;
      illegal_q  <= 1'b0;
      addr_q     <= '0;
      err_q      <= '0;
    end else begin
      s1_valid_q <= s1_load || (s1_valid_q && !s1_adv);
      s2_valid_q <= s2_load || (s2_valid_q && !out_ready);
      if (s1_load) s1_q <= dec;
      if (s2_load) begin
        instr_q   <= instr_d;
        illegal_q <= s1_q.illegal;
      end
      if (out_hs) begin
        addr_q <= addr_q + 32'd4;
        err_q  <= err_q + {7'd0, illegal_q && err_q != 8'hFF};
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus checked against a behavioural encoder model every output cycle
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  fmt = '0;
  logic [3:0]  alu_op = '0;
  logic [2:0]  mask = '0;
  logic [2:0]  br_type = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr, addr;
  logic        illegal;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { logic [32:0] e; int acc; } ent_t;
  ent_t        q[$];
  logic [31:0] exp_addr = '0;
  int          exp_err = 0;
  logic        saw_block;

  instr_encoder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .fmt(fmt), .alu_op(alu_op), .mask(mask), .br_type(br_type),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
    .illegal(illegal), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: {illegal, word} from the instruction-set rules
  function automatic logic [32:0] enc(input logic [2:0] f, input logic [3:0] op,
      input logic [2:0] m, input logic [2:0] bt, input logic [4:0] d, input logic [4:0] a,
      input logic [4:0] b, input logic [31:0] im);
    int si;
    logic ill, sh;
    logic [31:0] w, f3, f7, rdv, r1, r2;
    si  = signed'(im);
    rdv = {27'd0, d} << 7;
    r1  = {27'd0, a} << 15;
    r2  = {27'd0, b} << 20;
    f3  = ((op == 4'd9) ? 32'd0 : (op >= 4'd7) ? {28'd0, op} - 32'd1 :
           (op == 4'd6) ? 32'd5 : {28'd0, op}) << 12;
    f7  = (op == 4'd9 || op == 4'd6) ? 32'h4000_0000 : 32'd0;
    sh  = op == 4'd1 || op == 4'd5 || op == 4'd6;
    w   = '0;
    ill = 1'b1;
    case (f)
      3'd0: begin
        ill = op > 4'd9;
        w = f7 | r2 | r1 | f3 | rdv | 32'h33;
      end
      3'd1: begin
        ill = op >= 4'd9 || (sh ? im > 32'd31 : (si < -2048 || si > 2047));
        w = (sh ? (f7 | ((im & 32'd31) << 20)) : ((im & 32'hFFF) << 20)) | r1 | f3 | rdv | 32'h13;
      end
      3'd2: begin
        ill = m == 3'd3 || m == 3'd6 || m == 3'd7 || si < -2048 || si > 2047;
        w = ((im & 32'hFFF) << 20) | r1 | ({29'd0, m} << 12) | rdv | 32'h03;
      end
      3'd3: begin
        ill = m > 3'd2 || si < -2048 || si > 2047;
        w = (((im >> 5) & 32'd127) << 25) | r2 | r1 | ({29'd0, m} << 12) | ((im & 32'd31) << 7) | 32'h23;
      end
      3'd4: begin
        ill = bt == 3'd2 || bt == 3'd3 || si < -4096 || si > 4095 || im[0];
        w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'd63) << 25) | r2 | r1 |
            ({29'd0, bt} << 12) | (((im >> 1) & 32'd15) << 8) | (((im >> 11) & 32'd1) << 7) | 32'h63;
      end
      3'd5: begin
        ill = (im & 32'hFFF) != 32'd0;
        w = (im & 32'hFFFF_F000) | rdv | 32'h37;
      end
      3'd6: begin
        ill = si < -(1 << 20) || si > (1 << 20) - 1 || im[0];
        w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'd1023) << 21) |
            (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'd255) << 12) | rdv | 32'h6F;
      end
      default: ill = 1'b1;
    endcase
    return ill ? {1'b1, 32'h13} : {1'b0, w};
  endfunction

  // Compare process: every cycle, check outputs against the in-order model queue
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      exp_addr = '0;
      exp_err = 0;
      chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
      chk("rst_req_ready", {32'd0, req_ready}, 33'd0);
      chk("rst_instr", {1'b0, instr}, 33'd0);
      chk("rst_addr", {1'b0, addr}, 33'd0);
      chk("rst_err_cnt", {25'd0, err_cnt}, 33'd0);
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_output: got instr %h expected no output", instr);
        end else begin
          chk("out_instr", {1'b0, instr}, {1'b0, q[0].e[31:0]});
          chk("out_illegal", {32'd0, illegal}, {32'd0, q[0].e[32]});
          chk("out_addr", {1'b0, addr}, {1'b0, exp_addr});
          chk("out_err_cnt", {25'd0, err_cnt}, 33'(exp_err));
          if (out_ready) begin
            if (q[0].e[32] && exp_err < 255) exp_err++;
            exp_addr = exp_addr + 32'd4;
            void'(q.pop_front());
          end
        end
      end else if (q.size() > 0 && cyc >= q[0].acc + 2) begin
        chk("latency", {32'd0, out_valid}, 33'd1);
      end
      if (req_valid && req_ready)
        q.push_back('{enc(fmt, alu_op, mask, br_type, rd, rs1, rs2, imm), cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request
  task automatic send(input logic [2:0] f, input logic [3:0] op, input logic [2:0] m,
      input logic [2:0] bt, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
      input logic [31:0] im);
    int n = 0;
    fmt = f; alu_op = op; mask = m; br_type = bt; rd = d; rs1 = a; rs2 = b; imm = im;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 within 50 cycles");
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {32'd0, req_ready}, 33'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    chk("pin_add", enc(3'd0, 4'd0, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0), {1'b0, 32'h002081B3});
    chk("pin_sub", enc(3'd0, 4'd9, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0), {1'b0, 32'h402081B3});
    chk("pin_addi", enc(3'd1, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF), {1'b0, 32'hFFF00093});
    chk("pin_addi_big", enc(3'd1, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048), {1'b1, 32'h00000013});
    chk("pin_beq", enc(3'd4, 4'd0, 3'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8), {1'b0, 32'h00208463});
    chk("pin_jal", enc(3'd6, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048), {1'b0, 32'h001000EF});
    chk("pin_load_m3", enc(3'd2, 4'd0, 3'd3, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0), {1'b1, 32'h00000013});
    chk("pin_srai", enc(3'd1, 4'd6, 3'd0, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3), {1'b0, 32'h40315093});
    chk("pin_sw", enc(3'd3, 4'd0, 3'd2, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC), {1'b0, 32'hFE20AE23});

    repeat (3) @(posedge clk);
    #1;
    do_reset();

    send(3'd0, 4'd0, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    chk("lat_cycle1", {32'd0, out_valid}, 33'd0);
    tick();
    @(negedge clk);
    chk("lat_cycle2", {32'd0, out_valid}, 33'd1);
    chk("first_instr", {1'b0, instr}, {1'b0, 32'h002081B3});
    chk("first_addr", {1'b0, addr}, 33'd0);
    tick();

    send(3'd0, 4'd9, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(3'd1, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd9, 32'hFFFF_FFFF);
    send(3'd1, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(3'd4, 4'd0, 3'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(3'd6, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(3'd2, 4'd0, 3'd3, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0);
    send(3'd2, 4'd0, 3'd4, 3'd0, 5'd7, 5'd8, 5'd31, 32'hFFFF_FFFC);
    send(3'd3, 4'd0, 3'd2, 3'd0, 5'd0, 5'd5, 5'd6, 32'hFFFF_FFEC);
    send(3'd3, 4'd0, 3'd3, 3'd0, 5'd0, 5'd5, 5'd6, 32'd4);
    send(3'd1, 4'd1, 3'd0, 3'd0, 5'd4, 5'd4, 5'd0, 32'd5);
    send(3'd1, 4'd6, 3'd0, 3'd0, 5'd4, 5'd4, 5'd0, 32'd31);
    send(3'd1, 4'd5, 3'd0, 3'd0, 5'd4, 5'd4, 5'd0, 32'd32);
    send(3'd1, 4'd9, 3'd0, 3'd0, 5'd4, 5'd4, 5'd0, 32'd1);
    send(3'd1, 4'd7, 3'd0, 3'd0, 5'd2, 5'd3, 5'd0, 32'd2047);
    send(3'd1, 4'd8, 3'd0, 3'd0, 5'd2, 5'd3, 5'd0, 32'hFFFF_F800);
    send(3'd5, 4'd10, 3'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5000);
    send(3'd5, 4'd10, 3'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5001);
    send(3'd4, 4'd0, 3'd5, 3'd0, 5'd0, 5'd3, 5'd4, 32'hFFFF_F002);
    send(3'd4, 4'd0, 3'd0, 3'd0, 5'd0, 5'd3, 5'd4, 32'd4096);
    send(3'd4, 4'd0, 3'd2, 3'd0, 5'd0, 5'd3, 5'd4, 32'd4);
    send(3'd4, 4'd0, 3'd1, 3'd0, 5'd0, 5'd3, 5'd4, 32'd4095);
    send(3'd6, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFE);
    send(3'd6, 4'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
    send(3'd7, 4'd0, 3'd0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    send(3'd0, 4'd10, 3'd0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    send(3'd0, 4'd3, 3'd0, 3'd0, 5'd31, 5'd30, 5'd29, 32'hDEAD_BEEF);
    drain();

    send(3'd0, 4'd0, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(3'd0, 4'd4, 3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("midrst_addr", {1'b0, addr}, 33'd0);
    chk("midrst_err_cnt", {25'd0, err_cnt}, 33'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {32'd0, req_ready}, 33'd1);
    tick();

    out_ready = 1'b0;
    saw_block = 1'b0;
    fork
      begin
        send(3'd0, 4'd0, 3'd0, 3'd0, 5'd5, 5'd6, 5'd7, 32'd0);
        send(3'd0, 4'd7, 3'd0, 3'd0, 5'd8, 5'd9, 5'd10, 32'd0);
        send(3'd1, 4'd4, 3'd0, 3'd0, 5'd11, 5'd12, 5'd0, 32'd100);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        repeat (4) begin
          @(negedge clk);
          if (req_valid && !req_ready) saw_block = 1'b1;
        end
      end
    join
    chk("stall_ready_fell", {32'd0, saw_block}, 33'd1);
    drain();
    chk("stall_final_addr", {1'b0, addr}, 33'd12);

    for (int i = 0; i < 256; i++)
      send(3'd2, 4'd0, 3'd3, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0);
    drain();
    chk("err_saturate", {25'd0, err_cnt}, 33'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
